// File: rtl/enc_pkg.sv
// Shared constants and helpers for the 16-line request encoder path.
package enc_pkg;

  localparam int N_REQ       = 16;
  localparam int CODE_W      = 4;
  localparam int DEB_DIV_DEF = 1000;
  localparam int DEB_CNT_DEF = 4;

  function automatic logic [N_REQ-1:0] onehot4to16(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-to-4 priority encoder, highest index wins, zero latency.
// Two 8-to-3 halves; the upper half takes over whenever any of its bits is set.
module prio_enc16
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  logic [2:0] lo_idx;
  logic [2:0] hi_idx;
  logic       hi_sel;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i])     lo_idx = 3'(i);
      if (req[i + 8]) hi_idx = 3'(i);
    end
  end

  assign hi_sel = |req[15:8];
  assign code   = {hi_sel, hi_sel ? hi_idx : lo_idx};
  assign any    = |req;

endmodule

// File: rtl/req_enc16_sync.sv
// Sync + debounce 16 raw request lines, latch rising edges as pending, emit codes highest first.
// Latency: rise -> code_valid next cycle when idle; code held stable while code_valid & !code_ready.
module req_enc16_sync
  import enc_pkg::*;
#(
  parameter int DEB_DIV = DEB_DIV_DEF,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_REQ-1:0]  pend_out,
  output logic              ovf
);

  localparam int             PW        = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DEB_DIV - 1);
  localparam logic [3:0]     CNT_MAX   = 4'(DEB_CNT - 1);

  logic [N_REQ-1:0]  sync1_q, sync1_d;
  logic [N_REQ-1:0]  sync2_q, sync2_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [N_REQ-1:0]  deb_q, deb_d;
  logic [N_REQ-1:0]  deb_prev_q, deb_prev_d;
  logic [3:0]        cnt_q [N_REQ];
  logic [3:0]        cnt_d [N_REQ];
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic              tick;
  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  ack_mask;
  logic [CODE_W-1:0] nxt_code;
  logic              nxt_any;

  // Synchroniser, shared prescaler and per-line debounce counters.
  always_comb begin
    sync1_d    = req_in;
    sync2_d    = sync1_q;
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = ~deb_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Pending bitmap: a same-cycle rise beats the acknowledge on its line.
  always_comb begin
    rise     = deb_q & ~deb_prev_q;
    ack_mask = (valid_q && code_ready) ? onehot4to16(code_q) : '0;
    pend_d   = (pend_q & ~ack_mask) | rise;
    ovf_d    = |(rise & pend_q & ~ack_mask);
    code_d   = code_q;
    valid_d  = valid_q;
    if (!valid_q || code_ready) begin
      code_d  = nxt_code;
      valid_d = nxt_any;
    end
  end

  prio_enc16 u_prio (
    .req  (pend_d),
    .code (nxt_code),
    .any  (nxt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      pend_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      pend_q     <= pend_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign pend_out   = pend_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_req_enc16_sync.sv
// Bench for req_enc16_sync with DEB_DIV=4, DEB_CNT=3: directed scenarios plus randomized press rounds.
module tb_req_enc16_sync;
  import enc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_in;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              code_ready;
  logic [N_REQ-1:0]  pend_out;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  req_enc16_sync #(.DEB_DIV(4), .DEB_CNT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pend_out   (pend_out),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return {8'd0, pend_out, 2'b00, ovf, code_valid, code_out};
  endfunction

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (code_valid) ok = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit               ok;
    int               cnt;
    int               k;
    int               got_n;
    int               ovf_n;
    logic [N_REQ-1:0] mask;
    int               expq[$];

    // 1: reset and idle
    rst_n      = 1'b1;
    req_in     = '0;
    code_ready = 1'b0;
    #2 rst_n   = 1'b0;
    #1 check("rst_outs", outs(), 32'd0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      check("idle", outs(), 32'd0);
    end

    // 2: single press of line 5, held then acknowledged once
    req_in[5] = 1'b1;
    wait_valid(20, ok);
    check("t2_latency", {31'd0, ok}, 32'd1);
    check("t2_code", {28'd0, code_out}, 32'd5);
    for (int i = 0; i < 25; i++) begin
      step();
      check("t2_hold", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd5});
    end
    req_in     = '0;
    code_ready = 1'b1;
    step();
    code_ready = 1'b0;
    check("t2_ack_valid", {31'd0, code_valid}, 32'd0);
    check("t2_ack_pend", {16'd0, pend_out}, 32'd0);
    step(40);
    check("t2_release", {15'd0, code_valid, pend_out}, 32'd0);

    // 3: short glitch on line 9 never reaches pending
    req_in[9] = 1'b1;
    step(6);
    req_in = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      check("t3_glitch", {15'd0, code_valid, pend_out}, 32'd0);
    end

    // 4: simultaneous rise on 3, 12, 7 drains in descending order
    code_ready = 1'b1;
    req_in     = 16'h1088;
    wait_valid(20, ok);
    check("t4_latency", {31'd0, ok}, 32'd1);
    check("t4_first", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd12});
    step();
    check("t4_second", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd7});
    step();
    check("t4_third", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd3});
    step();
    check("t4_empty", {31'd0, code_valid}, 32'd0);
    req_in = '0;
    step(40);
    check("t4_pend", {16'd0, pend_out}, 32'd0);

    // Asynchronous reset while a code is presented
    code_ready = 1'b0;
    req_in[11] = 1'b1;
    step(30);
    check("t1_pre_rst", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd11});
    #2 rst_n = 1'b0;
    #1 check("t1_async_rst", outs(), 32'd0);
    req_in = '0;
    step(2);
    rst_n = 1'b1;
    step();

    // 5: second press while still pending merges into one event
    code_ready = 1'b0;
    ovf_n      = 0;
    for (int ph = 0; ph < 4; ph++) begin
      req_in[2] = (ph % 2 == 0);
      for (int i = 0; i < 40; i++) begin
        step();
        ovf_n += int'(ovf);
      end
    end
    check("t5_ovf", ovf_n, 32'd1);
    check("t5_code", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd2});
    code_ready = 1'b1;
    cnt        = 0;
    for (int i = 0; i < 10; i++) begin
      if (code_valid && code_ready) begin
        cnt++;
        check("t5_code_val", {28'd0, code_out}, 32'd2);
      end
      step();
    end
    code_ready = 1'b0;
    check("t5_deliver", cnt, 32'd1);

    // 6: acknowledge of code 4 lands on the same cycle as a new rise on line 4.
    // All segments are multiples of the tick period so each press sees identical timing.
    req_in[4] = 1'b1;
    step(40);
    req_in = '0;
    step(40);
    check("t6_first", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd4});
    req_in[4] = 1'b1;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ovf && k < 0) k = i;
    end
    req_in = '0;
    step(40);
    check("t6_calib", {31'd0, (k > 0)}, 32'd1);
    if (k < 1) k = 1;
    req_in[4] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      code_ready = (i == k - 1);
      step();
      if (i + 1 == k) begin
        check("t6_no_ovf", {31'd0, ovf}, 32'd0);
        check("t6_pend4", {31'd0, pend_out[4]}, 32'd1);
        check("t6_again", {27'd0, code_valid, code_out}, {27'd0, 1'b1, 4'd4});
      end
    end
    code_ready = 1'b0;
    req_in     = '0;
    step(40);
    code_ready = 1'b1;
    step(3);
    code_ready = 1'b0;
    check("t6_drain", {15'd0, code_valid, pend_out}, 32'd0);

    // Random rounds: a random set of lines pressed together, random consumer stalls
    for (int r = 0; r < 8; r++) begin
      mask = 16'($urandom_range(1, 65535));
      expq.delete();
      for (int i = N_REQ - 1; i >= 0; i--) if (mask[i]) expq.push_back(i);
      req_in = mask;
      got_n  = 0;
      ovf_n  = 0;
      for (int c = 0; c < 140; c++) begin
        if (c == 40) req_in = '0;
        code_ready = (c >= 110) ? 1'b1 : 1'($urandom_range(0, 1));
        if (code_valid && code_ready) begin
          got_n++;
          if (expq.size() > 0) check("rnd_code", {28'd0, code_out}, expq.pop_front());
        end
        step();
        ovf_n += int'(ovf);
      end
      code_ready = 1'b0;
      check("rnd_count", got_n, $countones(mask));
      check("rnd_ovf", ovf_n, 32'd0);
      check("rnd_idle", {15'd0, code_valid, pend_out}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_enc16_sync.md
Name: req_enc16_sync

Overview:
- Sequential front end for the 16-to-4 priority encoder path.
- Takes 16 raw asynchronous request lines (push-buttons or external strobes) and synchronises and debounces each one.
- Captures every rising edge as a sticky pending request.
- Emits one 4-bit code per request, highest index first, over a valid/ready handshake, so downstream logic sees each event exactly once.

Parameters:
- DEB_DIV, 1000, clock cycles per debounce sample tick (>=1; 1 = tick every cycle).
- DEB_CNT, 4, consecutive ticks with a changed sample needed to accept a new level (1..15).

Ports:
- clk  in  1  single system clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset, applied immediately; deassertion is synchronised externally.
- req_in  in  16  raw asynchronous request lines, active-high.
- code_out  out  4  index of the request being presented.
- code_valid  out  1  code_out holds a pending request.
- code_ready  in  1  consumer accepts code_out this cycle.
- pend_out  out  16  current pending bitmap, for debug or status.
- ovf  out  1  one-cycle pulse: an edge arrived on a line already pending.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync FFs, debounced levels, debounce counters, prescaler and pending all reset to 0.
  - code_out=0, code_valid=0, ovf=0.
  - Reset mid-handshake drops the presented code and all pending requests.
- Synchroniser: 2-FF per line. sync[i] lags req_in[i] by 2 clk.
- Prescaler: counts 0..DEB_DIV-1 and asserts tick for one cycle at wrap.
- Debounce, per line:
  - On tick, if sync[i] != deb[i], increment cnt[i]; else clear cnt[i].
  - When cnt[i] reaches DEB_CNT-1 on a tick with a mismatch, toggle deb[i] and clear cnt[i].
  - Glitches shorter than DEB_CNT ticks never change deb.
- Edge capture: rise[i] = deb[i] & ~deb_d[i], a one-cycle pulse. Falling edges are ignored.
- Pending update, each cycle: pend <= (pend & ~ack_mask) | rise.
  - ack_mask = one-hot(code_out) when code_valid & code_ready, else 0.
  - A rise on the line being acknowledged in the same cycle leaves that bit set: set wins.
- Overflow: ovf=1 for one cycle if any rise[i] hits a line with pend[i]=1 and no same-cycle ack on it. The event is merged, not queued.
- Output stage:
  - Registered. When code_valid=0, or code_valid & code_ready, load the highest set index of the next-state pend.
  - code_valid follows whether any bit of next-state pend is set.
  - While code_valid=1 and code_ready=0, code_out and code_valid are held stable. A newly arriving higher-priority request does not preempt the presented code.
- Latency:
  - rise at cycle t sets pend at t+1; code_valid is high at t+1 when the output stage was idle.
  - req_in step to code_valid = 2 sync + up to DEB_CNT*DEB_DIV + DEB_DIV + 2 cycles.
- Back-to-back: with code_ready held high, one code per cycle, descending index.
- pend_out = pend register, so a presented code remains visible in pend_out until it is acknowledged.

Decomposition:
- Shared package enc_pkg:
  - N_REQ=16, CODE_W=4.
  - Default DEB_DIV/DEB_CNT constants.
  - Function onehot4to16.
- One sub-module: prio_enc16.
  - Combinational, 16-bit in to 4-bit code plus any flag, highest index wins.
  - Built as two 8-to-3 priority halves with an upper-half select bit.
  - Reused by the downstream encoder stage.

Test Plan (DEB_DIV=4, DEB_CNT=3):
1. Reset then idle, req_in=0x0000 -> code_valid=0, code_out=0, pend_out=0x0000, ovf=0 for 200 cycles. Assert rst_n=0 mid-stream -> all outputs 0 in the same cycle.
2. Single press: req_in[5] high for 40 cycles, code_ready=0 -> code_valid rises within 2+12+4+2 cycles with code_out=5, held stable. Then code_ready=1 for 1 cycle -> code_valid=0 next cycle, pend_out=0x0000.
3. Glitch: req_in[9] high for 6 cycles -> no code_valid, pend_out stays 0x0000.
4. Priority and ordering: lines 3, 12 and 7 rise together with code_ready=1 -> codes 12, 7, 3 on consecutive cycles, then code_valid=0.
5. Overflow: press line 2, release, press again (each level held 40 cycles) with code_ready=0 -> a single ovf pulse on the second rise. After ready, exactly one code 2 is delivered.
6. Set-wins race: force rise[4] in the same cycle as the handshake accepting code 4 -> pend_out[4]=1 afterwards and code 4 is presented again.
